// File: rtl/timer_pkg.sv
// Shared mode encoding, widths and button-event arbitration for the countdown timer.
package timer_pkg;

  localparam int NUM_W        = 13;
  localparam int SECS_PER_MIN = 60;

  // Mode values match the text table inside pixel_Gen; 2'b11 has no meaning.
  typedef enum logic [1:0] {
    ST_FINISHED = 2'b00,
    ST_STOPPED  = 2'b01,
    ST_COUNTING = 2'b10
  } mode_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_CLEAR,
    EV_STOP,
    EV_START,
    EV_INC_MIN,
    EV_INC_SEC
  } event_e;

  // Only the highest-priority event of a cycle is acted on.
  function automatic event_e pick_event(input logic clear, input logic stop,
                                        input logic start, input logic inc_min,
                                        input logic inc_sec);
    event_e ev;
    ev = EV_NONE;
    if (clear)        ev = EV_CLEAR;
    else if (stop)    ev = EV_STOP;
    else if (start)   ev = EV_START;
    else if (inc_min) ev = EV_INC_MIN;
    else if (inc_sec) ev = EV_INC_SEC;
    return ev;
  endfunction

endpackage

// File: rtl/timer_ctrl_btn_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    sync1_d = in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pulse_d = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/timer_ctrl.sv
// Countdown-timer controller: button handling, 1 Hz countdown, mode sequencing and
// frame-synchronous commit of the displayed count and mode.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int CLK_HZ      = 25_000_000,
  parameter int MAX_SECONDS = 5999,
  parameter int NUM_W       = timer_pkg::NUM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_start,
  input  logic             btn_stop,
  input  logic             btn_clear,
  input  logic             btn_inc_min,
  input  logic             btn_inc_sec,
  input  logic             frame_sync,
  output logic [NUM_W-1:0] num,
  output logic [1:0]       state,
  output logic             done,
  output logic             alarm
);

  localparam int PS_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLK_HZ - 1);
  localparam logic [NUM_W-1:0] MAX_CNT  = NUM_W'(MAX_SECONDS);
  localparam logic [NUM_W-1:0] MIN_STEP = NUM_W'(SECS_PER_MIN);

  logic ev_start, ev_stop, ev_clear, ev_inc_min, ev_inc_sec;

  btn_edge u_start   (.clk(clk), .rst_n(rst_n), .in(btn_start),   .pulse(ev_start));
  btn_edge u_stop    (.clk(clk), .rst_n(rst_n), .in(btn_stop),    .pulse(ev_stop));
  btn_edge u_clear   (.clk(clk), .rst_n(rst_n), .in(btn_clear),   .pulse(ev_clear));
  btn_edge u_inc_min (.clk(clk), .rst_n(rst_n), .in(btn_inc_min), .pulse(ev_inc_min));
  btn_edge u_inc_sec (.clk(clk), .rst_n(rst_n), .in(btn_inc_sec), .pulse(ev_inc_sec));

  mode_e            mode_q, mode_d;
  logic [NUM_W-1:0] count_q, count_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             done_q, done_d;
  logic             alarm_q, alarm_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [1:0]       state_q, state_d;

  event_e           ev;
  logic             wrap;
  logic [PS_W-1:0]  ps_next;

  always_comb begin
    ev      = pick_event(ev_clear, ev_stop, ev_start, ev_inc_min, ev_inc_sec);
    wrap    = (ps_q == PS_LAST);
    ps_next = wrap ? '0 : ps_q + 1'b1;

    mode_d  = mode_q;
    count_d = count_q;
    ps_d    = ps_q;
    done_d  = 1'b0;
    alarm_d = alarm_q;

    // Display shadows only follow the live values on a frame boundary.
    num_d   = frame_sync ? count_q : num_q;
    state_d = frame_sync ? mode_q  : state_q;

    case (mode_q)
      ST_STOPPED: begin
        alarm_d = 1'b0;
        case (ev)
          EV_INC_SEC: count_d = (count_q >= MAX_CNT) ? MAX_CNT : count_q + 1'b1;
          EV_INC_MIN: count_d = (count_q > MAX_CNT - MIN_STEP) ? MAX_CNT : count_q + MIN_STEP;
          EV_CLEAR:   count_d = '0;
          EV_START:   if (count_q != '0) mode_d = ST_COUNTING;
          default:    ;
        endcase
      end

      // A stop holds the prescaler so that a resume finishes the interrupted second.
      ST_COUNTING: begin
        case (ev)
          EV_CLEAR: begin
            mode_d  = ST_STOPPED;
            count_d = '0;
            ps_d    = '0;
          end
          EV_STOP: mode_d = ST_STOPPED;
          default: begin
            ps_d = ps_next;
            if (wrap && count_q != '0) begin
              count_d = count_q - 1'b1;
              if (count_q == NUM_W'(1)) begin
                mode_d = ST_FINISHED;
                done_d = 1'b1;
              end
            end
          end
        endcase
      end

      ST_FINISHED: begin
        if (ev == EV_CLEAR || ev == EV_STOP || ev == EV_START) begin
          mode_d  = ST_STOPPED;
          count_d = '0;
          alarm_d = 1'b0;
          ps_d    = '0;
        end else begin
          ps_d = ps_next;
          if (wrap) alarm_d = ~alarm_q;
        end
      end

      default: mode_d = ST_STOPPED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q  <= ST_STOPPED;
      count_q <= '0;
      ps_q    <= '0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
      num_q   <= '0;
      state_q <= ST_STOPPED;
    end else begin
      mode_q  <= mode_d;
      count_q <= count_d;
      ps_q    <= ps_d;
      done_q  <= done_d;
      alarm_q <= alarm_d;
      num_q   <= num_d;
      state_q <= state_d;
    end
  end

  assign num   = num_q;
  assign state = state_q;
  assign done  = done_q;
  assign alarm = alarm_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: hand-derived vectors and sequences plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_timer_ctrl;

  localparam int CLK_HZ      = 10;
  localparam int MAX_SECONDS = 5999;
  localparam int NUM_W       = 13;

  // Button vector bit order: {clear, stop, start, inc_min, inc_sec}
  localparam logic [4:0] B_CLEAR = 5'b10000;
  localparam logic [4:0] B_STOP  = 5'b01000;
  localparam logic [4:0] B_START = 5'b00100;
  localparam logic [4:0] B_IMIN  = 5'b00010;
  localparam logic [4:0] B_ISEC  = 5'b00001;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_sync = 1'b0;
  logic [4:0]       btn = '0;
  logic [NUM_W-1:0] num;
  logic [1:0]       state;
  logic             done;
  logic             alarm;

  timer_ctrl #(
    .CLK_HZ(CLK_HZ),
    .MAX_SECONDS(MAX_SECONDS),
    .NUM_W(NUM_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_start(btn[2]),
    .btn_stop(btn[3]),
    .btn_clear(btn[4]),
    .btn_inc_min(btn[1]),
    .btn_inc_sec(btn[0]),
    .frame_sync(frame_sync),
    .num(num),
    .state(state),
    .done(done),
    .alarm(alarm)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Behavioural reference state
  int         m_count, m_mode, m_ticks, m_num, m_state;
  bit         m_alarm, m_done;
  logic [4:0] hist [1:4];

  int k;
  int rel_at;

  typedef struct {
    logic [4:0] mask;
    int         exp_num;
    int         exp_state;
  } vec_t;

  vec_t tbl [10];

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %0d required %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Spec-level model: a button event is the level seen three edges ago being high
  // while the level four edges ago was low; one event per cycle by priority.
  task automatic modelStep();
    logic [4:0] ev;
    int top;
    if (!rst_n) begin
      m_count = 0; m_mode = 1; m_ticks = 0; m_alarm = 0; m_done = 0;
      m_num = 0; m_state = 1;
      for (int i = 1; i <= 4; i++) hist[i] = '0;
      return;
    end
    ev = hist[3] & ~hist[4];
    hist[4] = hist[3]; hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = btn;
    if (frame_sync) begin
      m_num = m_count;
      m_state = m_mode;
    end
    m_done = 0;
    top = -1;
    for (int i = 4; i >= 0; i--) begin
      if (ev[i] && top < 0) top = i;
    end
    if (m_mode == 1) begin
      if (top == 0) m_count = (m_count + 1 > MAX_SECONDS) ? MAX_SECONDS : m_count + 1;
      else if (top == 1) m_count = (m_count + 60 > MAX_SECONDS) ? MAX_SECONDS : m_count + 60;
      else if (top == 4) m_count = 0;
      else if (top == 2 && m_count > 0) m_mode = 2;
    end else if (m_mode == 2) begin
      if (top == 4) begin
        m_count = 0; m_ticks = 0; m_mode = 1;
      end else if (top == 3) begin
        m_mode = 1;
      end else begin
        m_ticks++;
        if (m_ticks == CLK_HZ) begin
          m_ticks = 0;
          m_count--;
          if (m_count == 0) begin
            m_mode = 0;
            m_done = 1;
          end
        end
      end
    end else begin
      if (top >= 2) begin
        m_mode = 1; m_count = 0; m_alarm = 0; m_ticks = 0;
      end else begin
        m_ticks++;
        if (m_ticks == CLK_HZ) begin
          m_ticks = 0;
          m_alarm = !m_alarm;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      checkOutput("model_num", int'(num), m_num);
      checkOutput("model_state", int'(state), m_state);
      checkOutput("model_done", int'(done), int'(m_done));
      checkOutput("model_alarm", int'(alarm), int'(m_alarm));
    end
  end

  // Press a button mask for two cycles and leave time for the event to land.
  task automatic applyStimulus(input logic [4:0] mask);
    btn = mask;
    repeat (2) @(negedge clk);
    btn = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic advance(input int target);
    while (k < target) begin
      @(negedge clk);
      k++;
      if (k == rel_at) btn = '0;
    end
  endtask

  task automatic startSeq(input logic [4:0] mask);
    k = 0;
    btn = mask;
    rel_at = 2;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0] = '{B_IMIN, 60, 1};
    tbl[1] = '{B_IMIN, 120, 1};
    tbl[2] = '{B_ISEC, 121, 1};
    tbl[3] = '{B_ISEC, 122, 1};
    tbl[4] = '{B_ISEC, 123, 1};
    tbl[5] = '{B_CLEAR, 0, 1};
    tbl[6] = '{B_START, 0, 1};
    tbl[7] = '{B_STOP | B_ISEC, 0, 1};
    tbl[8] = '{B_ISEC | B_IMIN, 60, 1};
    tbl[9] = '{B_CLEAR | B_START, 0, 1};

    rst_n = 1'b0;
    frame_sync = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    checkOutput("reset_num", int'(num), 0);
    checkOutput("reset_state", int'(state), 1);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_alarm", int'(alarm), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].mask);
      checkOutput($sformatf("tbl%0d_num", i), int'(num), tbl[i].exp_num);
      checkOutput($sformatf("tbl%0d_state", i), int'(state), tbl[i].exp_state);
    end
    applyStimulus(B_CLEAR);

    // Saturation at the top of the range
    for (int i = 0; i < 99; i++) applyStimulus(B_IMIN);
    checkOutput("sat_5940", int'(num), 5940);
    applyStimulus(B_IMIN);
    checkOutput("sat_min_from_5940", int'(num), 5999);
    applyStimulus(B_CLEAR);
    for (int i = 0; i < 99; i++) applyStimulus(B_IMIN);
    for (int i = 0; i < 58; i++) applyStimulus(B_ISEC);
    checkOutput("sat_5998", int'(num), 5998);
    applyStimulus(B_IMIN);
    checkOutput("sat_min_5999", int'(num), 5999);
    applyStimulus(B_ISEC);
    checkOutput("sat_sec_5999", int'(num), 5999);
    applyStimulus(B_CLEAR);
    checkOutput("sat_clear", int'(num), 0);

    // Countdown from 2 to FINISHED, then alarm blink
    applyStimulus(B_ISEC);
    applyStimulus(B_ISEC);
    checkOutput("cd_load", int'(num), 2);
    startSeq(B_START);
    advance(4);  checkOutput("cd_state_pre", int'(state), 1);
    advance(5);  checkOutput("cd_state_counting", int'(state), 2);
    advance(14); checkOutput("cd_num_before_dec", int'(num), 2);
    advance(15); checkOutput("cd_num_1", int'(num), 1);
    advance(23); checkOutput("cd_done_early", int'(done), 0);
    advance(24); checkOutput("cd_done_pulse", int'(done), 1);
    advance(25); checkOutput("cd_done_after", int'(done), 0);
    checkOutput("cd_state_finished", int'(state), 0);
    checkOutput("cd_num_0", int'(num), 0);
    advance(33); checkOutput("alarm_pre", int'(alarm), 0);
    advance(34); checkOutput("alarm_on", int'(alarm), 1);
    advance(43); checkOutput("alarm_hold", int'(alarm), 1);
    advance(44); checkOutput("alarm_off", int'(alarm), 0);
    applyStimulus(B_STOP);
    checkOutput("fin_exit_state", int'(state), 1);
    checkOutput("fin_exit_alarm", int'(alarm), 0);

    // Stop with the prescaler at 7, then resume
    for (int i = 0; i < 5; i++) applyStimulus(B_ISEC);
    startSeq(B_START);
    advance(8);
    btn = B_STOP;
    rel_at = 10;
    advance(62);
    checkOutput("pause_num", int'(num), 5);
    checkOutput("pause_state", int'(state), 1);
    startSeq(B_START);
    advance(7); checkOutput("resume_num_hold", int'(num), 5);
    advance(8); checkOutput("resume_num_4", int'(num), 4);
    applyStimulus(B_CLEAR);
    checkOutput("run_clear_num", int'(num), 0);
    checkOutput("run_clear_state", int'(state), 1);

    // Stop on the same edge as a prescaler wrap
    for (int i = 0; i < 3; i++) applyStimulus(B_ISEC);
    startSeq(B_START);
    advance(20);
    btn = B_STOP;
    rel_at = 22;
    advance(26);
    checkOutput("stopwrap_num", int'(num), 2);
    checkOutput("stopwrap_state", int'(state), 1);
    startSeq(B_START);
    advance(5); checkOutput("stopwrap_resume_hold", int'(num), 2);
    advance(6); checkOutput("stopwrap_resume_dec", int'(num), 1);
    applyStimulus(B_CLEAR);

    // Display frozen without frame_sync, then reset mid-count
    for (int i = 0; i < 9; i++) applyStimulus(B_ISEC);
    checkOutput("freeze_load", int'(num), 9);
    frame_sync = 1'b0;
    startSeq(B_START);
    advance(44);
    checkOutput("freeze_num", int'(num), 9);
    checkOutput("freeze_state", int'(state), 1);
    frame_sync = 1'b1;
    advance(45);
    checkOutput("commit_num", int'(num), 5);
    checkOutput("commit_state", int'(state), 2);
    frame_sync = 1'b0;
    advance(46);
    checkOutput("commit_hold", int'(num), 5);
    rst_n = 1'b0;
    frame_sync = 1'b1;
    advance(47);
    checkOutput("midreset_num", int'(num), 0);
    checkOutput("midreset_state", int'(state), 1);
    rst_n = 1'b1;
    frame_sync = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) btn[4] = ~btn[4];
      if ($urandom_range(0, 29) == 0) btn[3] = ~btn[3];
      if ($urandom_range(0, 9) == 0)  btn[2] = ~btn[2];
      if ($urandom_range(0, 39) == 0) btn[1] = ~btn[1];
      if ($urandom_range(0, 7) == 0)  btn[0] = ~btn[0];
      frame_sync = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 999) != 0);
    end
    btn = '0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
